// File: rtl/param_seq_detector.sv
// Serial PAT_LEN-bit pattern detector with runtime reload, overlap select and saturating match count.
// y pulses one cycle after the completing bit is sampled; en=0 stalls sampling with history held.
module param_seq_detector #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1011,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               x,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int            FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;

    state_t             state;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_n;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_n;
    logic               match;

    // Once armed, the history window is full and stays full until flushed.
    always_comb begin
        hist_n = {hist[PAT_LEN-2:0], x};
        fill_n = (state == ARMED) ? FULL : fill + FW'(1);
        match  = (fill_n == FULL) && (hist_n == pat);
    end

    assign cnt_sat = &match_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat       <= RST_PATTERN;
            hist      <= '0;
            fill      <= '0;
            state     <= EMPTY;
            y         <= 1'b0;
            match_cnt <= '0;
        end else if (cfg_load) begin
            pat       <= cfg_pattern;
            hist      <= '0;
            fill      <= '0;
            state     <= EMPTY;
            y         <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            y <= match;
            if (match) begin
                if (!cnt_sat) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                if (overlap) begin
                    hist  <= hist_n;
                    fill  <= FULL;
                    state <= ARMED;
                end else begin
                    hist  <= '0;
                    fill  <= '0;
                    state <= EMPTY;
                end
            end else begin
                hist  <= hist_n;
                fill  <= fill_n;
                state <= (fill_n == FULL) ? ARMED : FILLING;
            end
        end else begin
            y <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: vector table, directed corner sequences and a randomized run against a bit-queue model.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, x, overlap, cfg_load;
    logic [3:0] cfg_pattern;
    logic       y, cnt_sat;
    logic [7:0] match_cnt;
    logic       y2, sat2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_seq_detector u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    param_seq_detector #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    // Reference: the bits sampled since the last flush, newest at the back.
    bit         mq[$];
    logic [3:0] mpat;
    int         mcnt;
    logic       my;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpat = 4'b1011;
        mcnt = 0;
        my   = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic b, input logic ov,
                              input logic ld, input logic [3:0] cp);
        bit hit;
        if (ld) begin
            mpat = cp;
            mq.delete();
            mcnt = 0;
            my   = 1'b0;
        end else if (e) begin
            mq.push_back(b);
            if (mq.size() > 4) void'(mq.pop_front());
            hit = (mq.size() == 4);
            for (int i = 0; i < mq.size(); i++)
                if (mq[i] != mpat[3-i]) hit = 1'b0;
            my = hit;
            if (hit) begin
                if (mcnt < 255) mcnt++;
                if (!ov) mq.delete();
            end
        end else begin
            my = 1'b0;
        end
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic drive(input logic e, input logic b, input logic ov,
                         input logic ld, input logic [3:0] cp);
        @(negedge clk);
        en = e; x = b; overlap = ov; cfg_load = ld; cfg_pattern = cp;
        @(posedge clk);
        #1;
        model_step(e, b, ov, ld, cp);
        chk("model_y",   int'(y),         int'(my));
        chk("model_cnt", int'(match_cnt), mcnt);
        chk("model_sat", int'(cnt_sat),   int'(mcnt == 255));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; x = 1'b0; overlap = 1'b1; cfg_load = 1'b0; cfg_pattern = 4'b0000;
        model_reset();
        #1;
        chk("rst_y",   int'(y),         0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_sat", int'(cnt_sat),   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic       en, x, ov;
        logic       y_exp;
        logic [7:0] cnt_exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, logic xb, logic ov, logic ye, int ce);
        vec_t t;
        t.rst = r; t.en = 1'b1; t.x = xb; t.ov = ov; t.y_exp = ye; t.cnt_exp = 8'(ce);
        return t;
    endfunction

    initial begin
        rst_n = 1'b0;
        en = 1'b0; x = 1'b0; overlap = 1'b1; cfg_load = 1'b0; cfg_pattern = 4'b0000;
        model_reset();

        // Stream 0101011101, overlap on: single match on the 7th bit.
        tbl.push_back(v(1,0,1,0,0)); tbl.push_back(v(0,1,1,0,0));
        tbl.push_back(v(0,0,1,0,0)); tbl.push_back(v(0,1,1,0,0));
        tbl.push_back(v(0,0,1,0,0)); tbl.push_back(v(0,1,1,0,0));
        tbl.push_back(v(0,1,1,1,1)); tbl.push_back(v(0,1,1,0,1));
        tbl.push_back(v(0,0,1,0,1)); tbl.push_back(v(0,1,1,0,1));
        // Stream 1011011, overlap on: matches on bits 4 and 7.
        tbl.push_back(v(1,1,1,0,0)); tbl.push_back(v(0,0,1,0,0));
        tbl.push_back(v(0,1,1,0,0)); tbl.push_back(v(0,1,1,1,1));
        tbl.push_back(v(0,0,1,0,1)); tbl.push_back(v(0,1,1,0,1));
        tbl.push_back(v(0,1,1,1,2));
        // Same stream, overlap off: only bit 4 matches.
        tbl.push_back(v(1,1,0,0,0)); tbl.push_back(v(0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,0)); tbl.push_back(v(0,1,0,1,1));
        tbl.push_back(v(0,0,0,0,1)); tbl.push_back(v(0,1,0,0,1));
        tbl.push_back(v(0,1,0,0,1));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].en, tbl[i].x, tbl[i].ov, 1'b0, 4'b0000);
            chk($sformatf("tbl_y[%0d]", i),   int'(y),         int'(tbl[i].y_exp));
            chk($sformatf("tbl_cnt[%0d]", i), int'(match_cnt), int'(tbl[i].cnt_exp));
        end

        // Gap with en=0 is transparent: 1,0, three idle cycles, then 1,1.
        do_reset();
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 0, 1, 0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 4'b0000);
            chk("gap_y", int'(y), 0);
        end
        drive(1, 1, 1, 0, 4'b0000);
        chk("gap_pre_y", int'(y), 0);
        drive(1, 1, 1, 0, 4'b0000);
        chk("gap_y_final", int'(y), 1);
        chk("gap_cnt", int'(match_cnt), 1);

        // Reload to 0000 after prior history and a count; four zeros complete it.
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 0, 1, 0, 4'b0000);
        drive(1, 1, 1, 1, 4'b0000);
        chk("load_y", int'(y), 0);
        chk("load_cnt_clr", int'(match_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 4'b0000);
            chk("load_early_y", int'(y), 0);
        end
        drive(1, 0, 1, 0, 4'b0000);
        chk("load_y_4th", int'(y), 1);
        chk("load_cnt", int'(match_cnt), 1);

        // 2-bit counter saturates at 3 while y keeps pulsing.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 1, 0, 4'b0000);
            drive(1, 0, 1, 0, 4'b0000);
            drive(1, 1, 1, 0, 4'b0000);
            chk("sat_pre_y", int'(y2), 0);
            drive(1, 1, 1, 0, 4'b0000);
            chk($sformatf("sat_y[%0d]", k),   int'(y2),   1);
            chk($sformatf("sat_cnt[%0d]", k), int'(cnt2), (k < 3) ? k : 3);
            chk($sformatf("sat_flag[%0d]", k), int'(sat2), int'(k >= 3));
        end

        // Async reset mid-cycle after a match and partial history.
        do_reset();
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 0, 1, 0, 4'b0000);
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 1, 1, 0, 4'b0000);
        chk("mid_pre_cnt", int'(match_cnt), 1);
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 0, 1, 0, 4'b0000);
        drive(1, 1, 1, 0, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y",   int'(y),         0);
        chk("mid_rst_cnt", int'(match_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 1, 0, 4'b0000);
        chk("mid_after_y", int'(y), 0);
        chk("mid_after_cnt", int'(match_cnt), 0);
        drive(1, 0, 1, 0, 4'b0000);
        drive(1, 1, 1, 0, 4'b0000);
        drive(1, 1, 1, 0, 4'b0000);
        chk("mid_restart_y", int'(y), 1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0,
                  4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised successor to the fixed single-pattern Moore sequence detector.
- Detects a PAT_LEN-bit serial pattern on input x. The pattern is set at reset and can be reloaded at runtime.
- Overlapping or non-overlapping detection is selectable at runtime. A sample-enable input and a saturating match counter are included.
- Sits between a serial bit source and downstream control or status logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (>=2).
- RST_PATTERN, 4'b1011, pattern loaded at reset. Width is PAT_LEN. MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; x is sampled on posedge only when en=1.
- x  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_load  in  1  load cfg_pattern and flush history.
- cfg_pattern  in  PAT_LEN  new pattern; MSB is the first bit.
- y  out  1  registered match pulse.
- match_cnt  out  CNT_W  number of matches; saturating.
- cnt_sat  out  1  high while match_cnt is all-ones.

Behaviour:
- Reset (rst_n=0, async):
  - pat=RST_PATTERN, hist=0, fill=0, state=EMPTY.
  - Outputs: y=0, match_cnt=0, cnt_sat=0.
- State:
  - Registers: pat[PAT_LEN], history shift register hist[PAT_LEN], fill counter fill (0..PAT_LEN).
  - FSM states: EMPTY (fill=0), FILLING (0<fill<PAT_LEN), ARMED (fill=PAT_LEN).
- Priority per posedge: cfg_load > en > idle.
- cfg_load=1 (en and x are ignored):
  - pat<=cfg_pattern, hist<=0, fill<=0, state<=EMPTY.
  - y<=0, match_cnt<=0.
- en=1, cfg_load=0:
  - hist_n = {hist[PAT_LEN-2:0], x}.
  - fill_n = min(fill+1, PAT_LEN).
  - match = (fill_n==PAT_LEN) && (hist_n==pat).
  - y<=match. Latency: y is high for exactly one cycle after the posedge that samples the completing bit.
- On match:
  - overlap=1: hist<=hist_n, fill<=PAT_LEN, state stays ARMED.
  - overlap=0: hist<=0, fill<=0, state<=EMPTY. The next match needs PAT_LEN fresh bits.
- On no match: hist<=hist_n, fill<=fill_n. State follows fill.
- en=0, cfg_load=0: hist, fill and state hold; y<=0. Gaps are transparent to pattern continuity.
- overlap is sampled at the match edge only; changing it mid-stream has no other effect.
- Counter:
  - match_cnt<=match_cnt+1 on each match unless it is all-ones; then it holds (no wrap).
  - cnt_sat is combinational from match_cnt==all-ones.
- Match on the same edge as cfg_load: impossible, since cfg_load has priority.
- Reset mid-stream: all partial history is lost; fill restarts from 0 after rst_n deasserts.
- No X propagation: x is only used when en=1. The bench drives x to a known value whenever en=1.

Test Plan:
- Default pattern 1011, overlap=1, en=1, x = 0,1,0,1,0,1,1,1,0,1 -> y pulses once, in the cycle after the 7th sampled bit; match_cnt=1.
- Stream 1,0,1,1,0,1,1 with overlap=1 -> y after bits 4 and 7, match_cnt=2. Same stream after reset with overlap=0 -> y only after bit 4, match_cnt=1.
- x=1,0 then en=0 for 3 cycles (x=1 during the gap) then en=1 with x=1,1 -> y=0 throughout the gap; single y pulse after the final bit; match_cnt=1.
- cfg_load with cfg_pattern=0000 after 2 bits of prior history, then x=0 x4 -> no y before the 4th zero; y after the 4th zero; match_cnt=1 (cleared by the load, then incremented).
- CNT_W=2, overlap=1, x=1,0,1,1 repeated 5 times -> match_cnt counts 1,2,3 then holds at 3; cnt_sat=1 from the 3rd match; y still pulses on the 4th and 5th matches.
- Feed 1,0,1, assert rst_n=0 mid-cycle, release, feed 1 -> y=0, match_cnt=0 immediately on assert, fill=1 after the last bit; no match.
